// File: rtl/vector_cond_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_cond_sequencer                                                    |
// | Per-lane {N,Z,C,V} flag file plus conditional-execution lane sequencer.  |
// | Build option: VCOND_SKIP_EN presents only lanes whose condition passed.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module vector_cond_sequencer #(
  parameter int LANES = 8,
  parameter int LW    = $clog2(LANES)   // derived; leave at default
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic [LW-1:0]    flag_lane,
  input  logic [1:0]       flag_wmask,
  input  logic [3:0]       flag_data,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_cond,
  input  logic             issue_regwrite,
  input  logic             issue_memwrite,
  output logic             lane_valid,
  input  logic             lane_ready,
  output logic [LW-1:0]    lane_idx,
  output logic             lane_en,
  output logic             lane_regwrite,
  output logic             lane_memwrite,
  output logic             done,
  output logic [LANES-1:0] cond_mask
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_flags [LANES];
  logic [LANES-1:0] r_mask;
  logic             r_regwrite;
  logic             r_memwrite;
  logic             r_issue_ready;
  logic             r_lane_valid;
  logic [LW-1:0]    r_lane_idx;
  logic             r_lane_en;
  logic             r_lane_rw;
  logic             r_lane_mw;
  logic             r_done;
  logic [LANES-1:0] r_cond_mask;

  logic [LANES-1:0] w_mask;
  logic [LANES-1:0] w_src_mask;
  logic [LW:0]      w_start;
  logic [LW:0]      w_next;
  logic             w_found;
  logic [LW-1:0]    w_lane;
  logic             w_en;
  logic             w_rw;
  logic             w_mw;

  // Odd codes are the complement of the even code below them.
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, res;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'b000:  res = z;
      3'b001:  res = c;
      3'b010:  res = n;
      3'b011:  res = v;
      3'b100:  res = c & ~z;
      3'b101:  res = (n == v);
      3'b110:  res = ~z & (n == v);
      default: res = 1'b1;
    endcase
    return res ^ cc[0];
  endfunction

`ifdef VCOND_SKIP_EN
  // Lowest set bit of m at or above start; returns LANES when none.
  function automatic logic [LW:0] first_from(input logic [LANES-1:0] m, input logic [LW:0] start);
    logic [LW:0] r;
    r = (LW+1)'(LANES);
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i] && ((LW+1)'(i) >= start)) r = (LW+1)'(i);
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) r_flags[i] <= 4'd0;
    end else if (flag_we) begin
      if (flag_wmask[1]) r_flags[flag_lane][3:2] <= flag_data[3:2];
      if (flag_wmask[0]) r_flags[flag_lane][1:0] <= flag_data[1:0];
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < LANES; i++) w_mask[i] = cond_eval(issue_cond, r_flags[i]);
  end

  // Next lane to present: first lane when idle, successor of current in RUN.
  always_comb begin
    w_src_mask = (r_state == S_IDLE) ? w_mask : r_mask;
    w_start    = (r_state == S_IDLE) ? '0 : ({1'b0, r_lane_idx} + (LW+1)'(1));
`ifdef VCOND_SKIP_EN
    w_next     = first_from(w_src_mask, w_start);
`else
    w_next     = w_start;
`endif
    w_found    = ~w_next[LW];
    w_lane     = w_next[LW-1:0];
    w_en       = w_src_mask[w_lane];
    w_rw       = ((r_state == S_IDLE) ? issue_regwrite : r_regwrite) & w_en;
    w_mw       = ((r_state == S_IDLE) ? issue_memwrite : r_memwrite) & w_en;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_mask        <= '0;
      r_regwrite    <= 1'b0;
      r_memwrite    <= 1'b0;
      r_issue_ready <= 1'b1;
      r_lane_valid  <= 1'b0;
      r_lane_idx    <= '0;
      r_lane_en     <= 1'b0;
      r_lane_rw     <= 1'b0;
      r_lane_mw     <= 1'b0;
      r_done        <= 1'b0;
      r_cond_mask   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (issue_valid) begin
            r_mask        <= w_mask;
            r_regwrite    <= issue_regwrite;
            r_memwrite    <= issue_memwrite;
            r_issue_ready <= 1'b0;
            if (w_found) begin
              r_lane_valid <= 1'b1;
              r_lane_idx   <= w_lane;
              r_lane_en    <= w_en;
              r_lane_rw    <= w_rw;
              r_lane_mw    <= w_mw;
              r_state      <= S_RUN;
            end else begin
              r_done      <= 1'b1;
              r_cond_mask <= w_mask;
              r_state     <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (lane_ready) begin
            if (w_found) begin
              r_lane_idx <= w_lane;
              r_lane_en  <= w_en;
              r_lane_rw  <= w_rw;
              r_lane_mw  <= w_mw;
            end else begin
              r_lane_valid <= 1'b0;
              r_lane_idx   <= '0;
              r_lane_en    <= 1'b0;
              r_lane_rw    <= 1'b0;
              r_lane_mw    <= 1'b0;
              r_done       <= 1'b1;
              r_cond_mask  <= r_mask;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done        <= 1'b0;
          r_cond_mask   <= '0;
          r_issue_ready <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign issue_ready   = r_issue_ready;
  assign lane_valid    = r_lane_valid;
  assign lane_idx      = r_lane_idx;
  assign lane_en       = r_lane_en;
  assign lane_regwrite = r_lane_rw;
  assign lane_memwrite = r_lane_mw;
  assign done          = r_done;
  assign cond_mask     = r_cond_mask;

endmodule
`default_nettype wire

// File: tb/tb_vector_cond_sequencer.sv
`default_nettype none
// Bench for vector_cond_sequencer: condition truth table, directed corner
// sequences, and randomized instructions against a flag/condition model.
module tb_vector_cond_sequencer;
  localparam int LANES = 8;
  localparam int LW    = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flag_we = 1'b0;
  logic [LW-1:0]    flag_lane = '0;
  logic [1:0]       flag_wmask = '0;
  logic [3:0]       flag_data = '0;
  logic             issue_valid = 1'b0;
  logic             issue_ready;
  logic [3:0]       issue_cond = '0;
  logic             issue_regwrite = 1'b0;
  logic             issue_memwrite = 1'b0;
  logic             lane_valid;
  logic             lane_ready = 1'b0;
  logic [LW-1:0]    lane_idx;
  logic             lane_en;
  logic             lane_regwrite;
  logic             lane_memwrite;
  logic             done;
  logic [LANES-1:0] cond_mask;

  int n_cmp = 0;
  int n_fail = 0;

  logic [3:0] mflags [LANES];

  vector_cond_sequencer #(.LANES(LANES)) dut (
    .clk(clk), .reset(reset),
    .flag_we(flag_we), .flag_lane(flag_lane), .flag_wmask(flag_wmask), .flag_data(flag_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_cond(issue_cond),
    .issue_regwrite(issue_regwrite), .issue_memwrite(issue_memwrite),
    .lane_valid(lane_valid), .lane_ready(lane_ready), .lane_idx(lane_idx), .lane_en(lane_en),
    .lane_regwrite(lane_regwrite), .lane_memwrite(lane_memwrite),
    .done(done), .cond_mask(cond_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference condition rules written straight from the condition table.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !(cf && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [LANES-1:0] model_mask(input logic [3:0] c);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = ref_cond(c, mflags[i]);
    return m;
  endfunction

  task automatic tick();
    logic fw;
    logic [LW-1:0] fl;
    logic [1:0] fm;
    logic [3:0] fd;
    fw = flag_we; fl = flag_lane; fm = flag_wmask; fd = flag_data;
    @(posedge clk);
    if (fw && reset) begin
      if (fm[1]) mflags[fl][3:2] = fd[3:2];
      if (fm[0]) mflags[fl][1:0] = fd[1:0];
    end
    #1;
  endtask

  task automatic write_flags(input logic [LW-1:0] l, input logic [1:0] m, input logic [3:0] d);
    flag_we = 1'b1; flag_lane = l; flag_wmask = m; flag_data = d;
    tick();
    flag_we = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_issue_ready"}, 32'(issue_ready), 32'd1);
    check({tag, "_lane_valid"}, 32'(lane_valid), 32'd0);
    check({tag, "_lane_idx"}, 32'(lane_idx), 32'd0);
    check({tag, "_lane_en"}, 32'(lane_en), 32'd0);
    check({tag, "_lane_rw"}, 32'(lane_regwrite), 32'd0);
    check({tag, "_lane_mw"}, 32'(lane_memwrite), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cond_mask"}, 32'(cond_mask), 32'd0);
  endtask

  // rmode: 0 ready always, 1 random ready + random flag traffic, 2 ready 1,0,0,1 then 1
  task automatic run_instr(input logic [3:0] cond, input logic rw, input logic mw, input int rmode,
                           input logic fw, input logic [LW-1:0] fl, input logic [1:0] fm,
                           input logic [3:0] fd, output logic [LANES-1:0] got, output int lat);
    logic [LANES-1:0] exp_mask;
    int q[$];
    int k, cyc;
    logic rdy, en;
    check("issue_ready_idle", 32'(issue_ready), 32'd1);
    exp_mask = model_mask(cond);
    issue_valid = 1'b1; issue_cond = cond; issue_regwrite = rw; issue_memwrite = mw;
    flag_we = fw; flag_lane = fl; flag_wmask = fm; flag_data = fd;
    tick();
    issue_valid = 1'b0; flag_we = 1'b0;
    for (int i = 0; i < LANES; i++) begin
`ifdef VCOND_SKIP_EN
      if (exp_mask[i]) q.push_back(i);
`else
      q.push_back(i);
`endif
    end
    lat = 1; k = 0; cyc = 0;
    while (k < q.size()) begin
      if (cyc > 300) begin
        check("lane_timeout", 32'(k), 32'(q.size()));
        break;
      end
      en = exp_mask[q[k]];
      check("lane_valid", 32'(lane_valid), 32'd1);
      check("lane_idx", 32'(lane_idx), 32'(q[k]));
      check("lane_en", 32'(lane_en), 32'(en));
      check("lane_regwrite", 32'(lane_regwrite), 32'(rw & en));
      check("lane_memwrite", 32'(lane_memwrite), 32'(mw & en));
      check("done_early", 32'(done), 32'd0);
      case (rmode)
        0: rdy = 1'b1;
        1: begin
          rdy = 1'($urandom_range(0, 1));
          flag_we = 1'($urandom_range(0, 1));
          flag_lane = LW'($urandom); flag_wmask = 2'($urandom); flag_data = 4'($urandom);
        end
        default: rdy = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
      endcase
      lane_ready = rdy;
      tick();
      lane_ready = 1'b0; flag_we = 1'b0;
      lat++; cyc++;
      if (rdy) k++;
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_cond_mask", 32'(cond_mask), 32'(exp_mask));
    check("done_lane_valid", 32'(lane_valid), 32'd0);
    check("done_issue_ready", 32'(issue_ready), 32'd0);
    got = cond_mask;
    tick();
    check("post_done", 32'(done), 32'd0);
    check("post_issue_ready", 32'(issue_ready), 32'd1);
    check("post_cond_mask", 32'(cond_mask), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES-1:0] got;
    int lat;
    for (int i = 0; i < LANES; i++) mflags[i] = 4'd0;

    vecs[0]  = '{4'b0100, 4'd0,  1'b1};  vecs[1]  = '{4'b0000, 4'd0,  1'b0};
    vecs[2]  = '{4'b0100, 4'd1,  1'b0};  vecs[3]  = '{4'b0010, 4'd2,  1'b1};
    vecs[4]  = '{4'b0000, 4'd3,  1'b1};  vecs[5]  = '{4'b1000, 4'd4,  1'b1};
    vecs[6]  = '{4'b1000, 4'd5,  1'b0};  vecs[7]  = '{4'b0001, 4'd6,  1'b1};
    vecs[8]  = '{4'b0001, 4'd7,  1'b0};  vecs[9]  = '{4'b0010, 4'd8,  1'b1};
    vecs[10] = '{4'b0110, 4'd8,  1'b0};  vecs[11] = '{4'b0110, 4'd9,  1'b1};
    vecs[12] = '{4'b1001, 4'd10, 1'b1};  vecs[13] = '{4'b1000, 4'd11, 1'b1};
    vecs[14] = '{4'b0000, 4'd12, 1'b1};  vecs[15] = '{4'b0100, 4'd12, 1'b0};
    vecs[16] = '{4'b0100, 4'd13, 1'b1};  vecs[17] = '{4'b1111, 4'd14, 1'b1};
    vecs[18] = '{4'b0000, 4'd15, 1'b0};  vecs[19] = '{4'b1010, 4'd10, 1'b0};

    repeat (2) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk) reset = 1'b1;
    tick();
    check_idle("idle");

    // Lane 3 Z=1 then EQ: only lane 3 passes.
    write_flags(3'd3, 2'b10, 4'b0100);
    run_instr(4'd0, 1'b1, 1'b0, 0, 1'b0, '0, '0, '0, got, lat);
    check("eq_lane3_mask", 32'(got), 32'h08);
`ifdef VCOND_SKIP_EN
    check("eq_lane3_latency", 32'(lat), 32'd2);
`else
    check("eq_lane3_latency", 32'(lat), 32'd9);
`endif

    // Flag write in the issue cycle is not seen by that instruction.
    run_instr(4'd0, 1'b0, 1'b0, 0, 1'b1, 3'd0, 2'b10, 4'b0100, got, lat);
    check("same_cycle_old", 32'(got[0]), 32'd0);
    run_instr(4'd0, 1'b0, 1'b0, 0, 1'b0, '0, '0, '0, got, lat);
    check("same_cycle_new", 32'(got[0]), 32'd1);

    // Partial write leaves N=1,Z=1,C=0,V=0 on lane 2.
    write_flags(3'd2, 2'b11, 4'b1111);
    write_flags(3'd2, 2'b01, 4'b0000);
    run_instr(4'd10, 1'b1, 1'b1, 0, 1'b0, '0, '0, '0, got, lat);
    check("partial_ge", 32'(got[2]), 32'd0);
    run_instr(4'd11, 1'b1, 1'b1, 0, 1'b0, '0, '0, '0, got, lat);
    check("partial_lt", 32'(got[2]), 32'd1);
    run_instr(4'd9, 1'b1, 1'b1, 0, 1'b0, '0, '0, '0, got, lat);
    check("partial_ls", 32'(got[2]), 32'd1);

    // lane_ready 1,0,0,1 stretches completion by two cycles.
    run_instr(4'd14, 1'b1, 1'b1, 2, 1'b0, '0, '0, '0, got, lat);
    check("stall_latency", 32'(lat), 32'd11);
    check("stall_mask", 32'(got), 32'hFF);

    run_instr(4'd15, 1'b1, 1'b1, 0, 1'b0, '0, '0, '0, got, lat);
    check("nv_mask", 32'(got), 32'h00);
`ifdef VCOND_SKIP_EN
    check("nv_latency", 32'(lat), 32'd1);
`else
    check("nv_latency", 32'(lat), 32'd9);
`endif

    // Condition-code truth table through lane 0.
    for (int i = 0; i < 20; i++) begin
      write_flags(3'd0, 2'b11, vecs[i].flags);
      run_instr(vecs[i].cond, 1'b1, 1'b0, 0, 1'b0, '0, '0, '0, got, lat);
      check($sformatf("cond_tbl_%0d", i), 32'(got[0]), 32'(vecs[i].exp));
    end

    // Reset in the middle of RUN aborts without a done pulse.
    issue_valid = 1'b1; issue_cond = 4'd14; issue_regwrite = 1'b1; issue_memwrite = 1'b0;
    tick();
    issue_valid = 1'b0; lane_ready = 1'b1;
    tick(); tick(); tick();
    #2 reset = 1'b0;
    for (int i = 0; i < LANES; i++) mflags[i] = 4'd0;
    #1 check_idle("midrun_reset");
    lane_ready = 1'b0;
    tick(); tick();
    @(negedge clk) reset = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("post_reset_done", 32'(done), 32'd0);
      check("post_reset_valid", 32'(lane_valid), 32'd0);
      tick();
    end
    check_idle("post_reset");
    run_instr(4'd14, 1'b0, 1'b1, 0, 1'b0, '0, '0, '0, got, lat);
    check("post_reset_al", 32'(got), 32'hFF);
    run_instr(4'd0, 1'b0, 1'b1, 0, 1'b0, '0, '0, '0, got, lat);
    check("post_reset_eq", 32'(got), 32'h00);

    // Random flags, conditions, write intents and backpressure.
    for (int i = 0; i < 16; i++) write_flags(LW'($urandom), 2'($urandom), 4'($urandom));
    for (int i = 0; i < 40; i++) begin
      run_instr(4'($urandom), 1'($urandom), 1'($urandom), 1, 1'($urandom),
                LW'($urandom), 2'($urandom), 4'($urandom), got, lat);
      if ($urandom_range(0, 3) == 0) write_flags(LW'($urandom), 2'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vector_cond_sequencer.md
# vector_cond_sequencer

Per-lane conditional-execution sequencer for the vector execute stage. It holds a 4-bit {N,Z,C,V} flag register per lane and accepts one conditional vector instruction at a time. At acceptance it evaluates the condition code against every lane's flags and snapshots the result into a lane-enable mask. It then steps the lanes through the shared write-back/memory path one per handshake and gates RegWrite/MemWrite per lane.

## Interface
- LANES, 8: vector lanes; power of two, 2..32
- LW, $clog2(LANES): lane index width (derived)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- flag_we  in  1  per-lane flag update strobe from the lane ALU
- flag_lane  in  LW  lane being updated
- flag_wmask  in  2  [1]=write N,Z; [0]=write C,V
- flag_data  in  4  {N,Z,C,V}
- issue_valid  in  1  instruction offered
- issue_ready  out  1  sequencer can accept
- issue_cond  in  4  condition code
- issue_regwrite, issue_memwrite  in  1 each  unconditioned write intents
- lane_valid  out  1  a lane is presented downstream
- lane_ready  in  1  downstream accepts presented lane
- lane_idx  out  LW  presented lane
- lane_en  out  1  condition passed for presented lane
- lane_regwrite, lane_memwrite  out  1 each  intent AND lane_en
- done  out  1  one-cycle completion pulse
- cond_mask  out  LANES  snapshot mask; valid while done=1

## Operation
- Flag file: per lane, N/Z update iff flag_we & flag_wmask[1] & lane match; C/V update iff flag_we & flag_wmask[0] & lane match. Writes are accepted in any FSM state.
- Condition encoding (N,Z,C,V):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !(C&!Z)
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE !(!Z&(N==V))
  - 1110 AL 1; 1111 NV 0
  - No undefined codes; no X is ever produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: issue_ready=1. On issue_valid, all LANES conditions are evaluated from the registered flag file (pre-write values if flag_we fires the same cycle). The mask, cond, regwrite and memwrite are latched, the lane pointer is set to the first lane to present, and the FSM goes to RUN.
  - RUN: lane_valid=1 and lane_idx=pointer. lane_en=mask[pointer], lane_regwrite=regwrite_q&lane_en, lane_memwrite=memwrite_q&lane_en. Outputs stay stable until lane_valid&lane_ready. On that handshake the pointer advances; after the last presented lane the FSM goes to DONE.
  - DONE: done=1 and cond_mask=snapshot for one cycle, then IDLE. issue_ready=0 in DONE.
- Flag writes during RUN/DONE never alter the snapshot.
- Lanes are presented in ascending index order.

## Timing
- Reset, and all outputs in IDLE: issue_ready=1; lane_valid, lane_idx, lane_en, lane_regwrite, lane_memwrite, done and cond_mask are all 0.
- Reset also clears the flag file to 0 and the FSM to IDLE.
- Reset asserted mid-RUN aborts the instruction immediately; no done pulse is produced.
- Acceptance at cycle T: first lane presented at T+1. With lane_ready held 1, one lane per cycle.
- Without skip: done at T+1+LANES; next acceptance possible at T+2+LANES.
- lane_ready low stalls the pointer with no limit; outputs are held.
- A flag write to lane k at cycle T is visible to an instruction accepted at T+1 or later.

## Configuration
- VCOND_SKIP_EN defined: RUN presents only lanes with mask=1, so lane_en is always 1 when lane_valid=1. If the mask is all zero, the FSM goes IDLE -> DONE directly: done at T+1, and no lane handshakes occur.
- VCOND_SKIP_EN undefined: every lane is presented and lane_en reports the mask bit. Latency is fixed as above.

## Test plan
- Reset, then write lane 3 flags Z=1 (wmask=10, data=0100); issue EQ, regwrite=1, lane_ready=1 -> lanes 0..7 presented at T+1..T+8; only lane 3 has lane_en=1 and lane_regwrite=1; done at T+9 with cond_mask=8'b0000_1000.
- flag_we to lane 0 (Z=1) in the same cycle as an EQ issue -> lane 0 lane_en=0 (old value); a second EQ issue -> lane 0 lane_en=1.
- Partial write: lane 2 data=1111, then wmask=01 with data=0000 -> flags N=1,Z=1,C=0,V=0; GE fails, LT passes, LS passes.
- Toggle lane_ready 1,0,0,1 during RUN -> lane_idx/lane_en held while ready=0; done timing extends by 2 cycles.
- With VCOND_SKIP_EN: NV issue -> done at T+1, cond_mask=0, no lane_valid. AL issue -> 8 lanes presented, all with lane_en=1.
- Drive reset low at T+4 of a RUN -> all outputs 0 and issue_ready=1 after release; no done; flag file reads 0 (AL mask all ones, EQ mask all zeros).
